divider_32bit: RTL and testbench

Multi-cycle 32-bit integer divider for the processor's DIV/DIVU/REM/REMU datapath. It is the subtract-direction counterpart to the 32-bit adder. It uses restoring division, producing one quotient bit per clock from a 33-bit trial subtraction. Operands are accepted with a start pulse. Quotient, remainder and status flags are held stable from the done pulse until the next accepted start.

---
 rtl/divider_32bit.sv | 197 +++++++++++++++++++
 tb/tb_divider_32bit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
// ----------------------------------------------------------------------------
// divider_32bit
//
// Multi-cycle restoring divider for the DIV/DIVU/REM/REMU datapath. One
// quotient bit is produced per clock from a 33-bit trial subtraction. The
// operation runs on unsigned magnitudes, and the signs are reapplied in a
// single fix-up cycle.
//
// Timing from the start edge E0:
//   normal:         E1..E32 iterate, E33 fix-up, done high after E33
//   divide by zero: done high directly after E0
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        operation request, sampled only while idle
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high from the accepting edge until the edge leaving DONE
//   done         one-cycle pulse, results valid
//   quotient     result quotient (held until the next result)
//   remainder    result remainder (held until the next result)
//   div_by_zero  divisor was zero for the last operation
//   overflow     signed -2^31 / -1 for the last operation
// ----------------------------------------------------------------------------
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Working registers. quo_reg starts out holding the dividend magnitude
    // and is shifted left each iteration, so the quotient bits fill in
    // from the bottom as the dividend bits leave at the top.
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_mag_reg;
    logic             dvd_neg_reg;
    logic             dvs_neg_reg;
    logic             signed_reg;
    logic             ovf_pend_reg;
    logic [CNT_W-1:0] iter_reg;

    // Result registers, held between operations.
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;
    logic             ovf_reg;

    // Operand magnitudes. The magnitude of -2^31 is 32'h8000_0000, which is
    // still correct when the value is read as unsigned.
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             divisor_zero;

    assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign divisor_zero = (divisor == '0);

    // Restoring step. The shifted partial remainder needs WIDTH+1 bits.
    // Because rem < divisor holds, the top bit of the trial difference is a
    // reliable borrow (negative) indicator.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag_reg};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (iter_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_mag_reg   <= '0;
            dvd_neg_reg   <= 1'b0;
            dvs_neg_reg   <= 1'b0;
            signed_reg    <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            iter_reg      <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg      <= '0;
                        quo_reg      <= dividend_abs;
                        dvs_mag_reg  <= divisor_abs;
                        dvd_neg_reg  <= dividend[WIDTH-1];
                        dvs_neg_reg  <= divisor[WIDTH-1];
                        signed_reg   <= is_signed;
                        ovf_pend_reg <= is_signed && (dividend == MIN_NEG) && (divisor == '1);
                        iter_reg     <= '0;
                        // A zero divisor skips the iterations entirely, so the
                        // results and flags are written at the accepting edge.
                        if (divisor_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                            ovf_reg       <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_reg <= trial[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    iter_reg <= iter_reg + 1'b1;
                end
                FIX: begin
                    // Truncating division: the quotient is negative when the
                    // operand signs differ, and the remainder follows the
                    // dividend's sign.
                    quotient_reg  <= (signed_reg && (dvd_neg_reg ^ dvs_neg_reg)) ? -quo_reg : quo_reg;
                    remainder_reg <= (signed_reg && dvd_neg_reg) ? -rem_reg : rem_reg;
                    dbz_reg       <= 1'b0;
                    ovf_reg       <= ovf_pend_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_divider_32bit.sv
// ----------------------------------------------------------------------------
// tb_divider_32bit
//
// Self-checking bench for divider_32bit. Results are compared against a
// reference model built on plain 64-bit integer division. The bench covers
// directed cases, randomized operands, the start handshake, back-to-back
// operation and a reset asserted in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    divider_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Reference model: truncating integer division on 64-bit integers, so
    // -2^31 / -1 does not trap and simply wraps to 32'h8000_0000.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
            ov = 1'b0;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
            ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
            ov = 1'b0;
        end
    endfunction

    // Issue one operation and collect what the DUT shows. lat is the number
    // of rising edges after the start edge before done is seen, or -1 if
    // done never arrives. bcnt counts the sampled cycles with busy high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int lat, output int bcnt,
                         output logic busy_after, output logic done_after);
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        // Operands may change freely once they have been accepted.
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
        lat = -1;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        @(negedge clk);
        busy_after = busy;
        done_after = done;
        n_vec++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        if ({busy, done, div_by_zero, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got busy/done/dz/ov=%b want 0000", {busy, done, div_by_zero, overflow});
        end
        if ({quotient, remainder} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_results: got q=%h r=%h want 0", quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        n_vec++;
        $display("reset: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } vec_t;

    task automatic check_op_inline_directed(input vec_t v);
        logic [31:0] q, r, eq, er;
        logic dz, ov, edz, eov, ba, da;
        int lat, bcnt, elat;
        do_op(v.a, v.b, v.s, q, r, dz, ov, lat, bcnt, ba, da);
        model(v.a, v.b, v.s, eq, er, edz, eov);
        elat = (v.b == 32'd0) ? 0 : 33;
        $display("directed: %h / %h s=%0b -> q=%h r=%h dz=%b ov=%b lat=%0d", v.a, v.b, v.s, q, r, dz, ov, lat);
        if (q !== eq) begin n_err++; $display("FAIL dir_quotient %h/%h s=%0b: got %h want %h", v.a, v.b, v.s, q, eq); end
        if (r !== er) begin n_err++; $display("FAIL dir_remainder %h/%h s=%0b: got %h want %h", v.a, v.b, v.s, r, er); end
        if (dz !== edz) begin n_err++; $display("FAIL dir_div_by_zero %h/%h: got %b want %b", v.a, v.b, dz, edz); end
        if (ov !== eov) begin n_err++; $display("FAIL dir_overflow %h/%h s=%0b: got %b want %b", v.a, v.b, v.s, ov, eov); end
        if (lat !== elat) begin n_err++; $display("FAIL dir_latency %h/%h: got %0d want %0d", v.a, v.b, lat, elat); end
        if (bcnt !== elat + 1) begin n_err++; $display("FAIL dir_busy_cycles %h/%h: got %0d want %0d", v.a, v.b, bcnt, elat + 1); end
        if (ba !== 1'b0 || da !== 1'b0) begin n_err++; $display("FAIL dir_after_done: got busy=%b done=%b want 0 0", ba, da); end
    endtask

    task automatic test_directed();
        vec_t tbl [9];
        tbl = '{
            '{32'd100,        32'd7,          1'b0},
            '{32'hFFFF_FFF9,  32'd2,          1'b1},
            '{32'd7,          32'hFFFF_FFFE,  1'b1},
            '{32'hFFFF_FFFF,  32'd1,          1'b0},
            '{32'd1234,       32'd0,          1'b0},
            '{32'd1234,       32'd0,          1'b1},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0},
            '{32'h8000_0000,  32'd3,          1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            check_op_inline_directed(tbl[i]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        logic s, dz, ov, edz, eov, ba, da;
        int lat, bcnt, elat, mode;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            mode = int'($urandom_range(0, 7));
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, q, r, dz, ov, lat, bcnt, ba, da);
            model(a, b, s, eq, er, edz, eov);
            elat = (b == 32'd0) ? 0 : 33;
            $display("random: %h / %h s=%0b -> q=%h r=%h dz=%b ov=%b lat=%0d", a, b, s, q, r, dz, ov, lat);
            if (q !== eq) begin n_err++; $display("FAIL rnd_quotient %h/%h s=%0b: got %h want %h", a, b, s, q, eq); end
            if (r !== er) begin n_err++; $display("FAIL rnd_remainder %h/%h s=%0b: got %h want %h", a, b, s, r, er); end
            if (dz !== edz || ov !== eov) begin
                n_err++;
                $display("FAIL rnd_flags %h/%h s=%0b: got dz=%b ov=%b want dz=%b ov=%b", a, b, s, dz, ov, edz, eov);
            end
            if (lat !== elat || bcnt !== elat + 1) begin
                n_err++;
                $display("FAIL rnd_timing %h/%h: got lat=%0d busy=%0d want lat=%0d busy=%0d", a, b, lat, bcnt, elat, elat + 1);
            end
            if (ba !== 1'b0 || da !== 1'b0) begin n_err++; $display("FAIL rnd_after_done: got busy=%b done=%b want 0 0", ba, da); end
        end
    endtask

    task automatic test_handshake();
        int ndone;
        logic [31:0] q_seen, r_seen;
        ndone = 0;
        q_seen = '0;
        r_seen = '0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        // A second request while busy must be ignored.
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    q_seen = quotient;
                    r_seen = remainder;
                end
            end
        end
        n_vec++;
        $display("handshake: 50/5 with ignored 9/3 -> dones=%0d q=%h r=%h", ndone, q_seen, r_seen);
        if (ndone !== 1) begin n_err++; $display("FAIL hs_done_count: got %0d want 1", ndone); end
        if (q_seen !== 32'd10 || r_seen !== 32'd0) begin
            n_err++;
            $display("FAIL hs_result: got q=%h r=%h want q=%h r=%h", q_seen, r_seen, 32'd10, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic got1, got2, b_gap, b_new;
        logic [31:0] q1, r1, q2, r2;
        got1 = 1'b0; got2 = 1'b0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got1 = 1'b1;
                break;
            end
        end
        q1 = quotient; r1 = remainder;
        // start stays high; the next operation takes these operands.
        dividend = 32'd200; divisor = 32'd9;
        @(negedge clk);
        b_gap = busy;
        @(negedge clk);
        b_new = busy;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got2 = 1'b1;
                break;
            end
        end
        q2 = quotient; r2 = remainder;
        @(negedge clk);
        n_vec += 2;
        $display("back_to_back: 100/7 -> q=%h r=%h, 200/9 -> q=%h r=%h, gap busy=%b next busy=%b", q1, r1, q2, r2, b_gap, b_new);
        if (!got1 || q1 !== 32'd14 || r1 !== 32'd2) begin
            n_err++;
            $display("FAIL b2b_first: got done=%b q=%h r=%h want done=1 q=%h r=%h", got1, q1, r1, 32'd14, 32'd2);
        end
        if (b_gap !== 1'b0 || b_new !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_restart: got gap busy=%b next busy=%b want 0 1", b_gap, b_new);
        end
        if (!got2 || q2 !== 32'd22 || r2 !== 32'd2) begin
            n_err++;
            $display("FAIL b2b_second: got done=%b q=%h r=%h want done=1 q=%h r=%h", got2, q2, r2, 32'd22, 32'd2);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        logic [31:0] q, r;
        logic dz, ov, ba, da;
        int lat, bcnt;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        if ({busy, done, div_by_zero, overflow} !== 4'b0000 || {quotient, remainder} !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_vec++;
        $display("reset_mid: aborted 1000/3, activity after reset=%0d", ndone);
        if (ndone !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d active cycles want 0", ndone); end
        do_op(32'd81, 32'd9, 1'b0, q, r, dz, ov, lat, bcnt, ba, da);
        $display("reset_mid: 81/9 -> q=%h r=%h lat=%0d", q, r, lat);
        if (q !== 32'd9 || r !== 32'd0 || lat !== 33) begin
            n_err++;
            $display("FAIL mid_reset_recover: got q=%h r=%h lat=%0d want q=%h r=%h lat=33", q, r, lat, 32'd9, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
